// File: rtl/iq_phase_demodulator_pkg.sv
// Shared constants for the I/Q phase demodulator: arctangent table, CORDIC gain, FSM states.
// Optional feature macro used elsewhere in this slice: IQ_PHASE_UNWRAP_EN.
package nice_cordic_pkg;

  // atan(2^-k) in turns, scaled so that 2^24 LSB is one full turn.
  localparam logic [23:0] ATAN_LUT [0:23] = '{
    24'd2097152, 24'd1238021, 24'd654136, 24'd332050,
    24'd166669,  24'd83416,   24'd41718,  24'd20860,
    24'd10430,   24'd5215,    24'd2608,   24'd1304,
    24'd652,     24'd326,     24'd163,    24'd81,
    24'd41,      24'd20,      24'd10,     24'd5,
    24'd3,       24'd1,       24'd1,      24'd0
  };

  localparam int unsigned CORDIC_GAIN_Q16 = 107922;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREROT = 2'd1,
    ROTATE = 2'd2,
    FINISH = 2'd3
  } cordic_state_t;

endpackage

// File: rtl/iq_phase_demodulator_if.sv
// Sample/result bundle between the Hilbert stage, the demodulator and its consumer.
// phase_unwrapped_o exists only when IQ_PHASE_UNWRAP_EN is defined.
interface iq_phase_demodulator_if #(
  parameter int IN_W = 24,
  parameter int PH_W = 24
);
  logic                   tick_i;
  logic signed [IN_W-1:0] i_i;
  logic signed [IN_W-1:0] q_i;
  logic signed [PH_W-1:0] phase_o;
  logic        [IN_W:0]   magnitude_o;
  logic                   done_o;
  logic                   busy_o;
  logic                   overrun_o;
`ifdef IQ_PHASE_UNWRAP_EN
  logic signed [31:0]     phase_unwrapped_o;
`endif

  modport master (
    output tick_i, i_i, q_i,
    input  phase_o, magnitude_o, done_o, busy_o, overrun_o
`ifdef IQ_PHASE_UNWRAP_EN
    , input phase_unwrapped_o
`endif
  );

  modport slave (
    input  tick_i, i_i, q_i,
    output phase_o, magnitude_o, done_o, busy_o, overrun_o
`ifdef IQ_PHASE_UNWRAP_EN
    , output phase_unwrapped_o
`endif
  );
endinterface

// File: rtl/iq_phase_demodulator_microrotation.sv
// One combinational CORDIC vectoring step; drives y toward zero and accumulates the angle in z.
module cordic_microrotation
  import nice_cordic_pkg::*;
#(
  parameter int XW   = 26,
  parameter int PH_W = 24
) (
  input  logic signed [XW-1:0]   x,
  input  logic signed [XW-1:0]   y,
  input  logic        [PH_W-1:0] z,
  input  logic        [4:0]      k,
  output logic signed [XW-1:0]   x_nx,
  output logic signed [XW-1:0]   y_nx,
  output logic        [PH_W-1:0] z_nx
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic        [PH_W-1:0] atan_k;

  assign x_sh = x >>> k;
  assign y_sh = y >>> k;

  // The table is in 24-bit turns; rescale to the configured phase width.
  if (PH_W >= 24) begin : g_atan_up
    assign atan_k = PH_W'(ATAN_LUT[k]) << (PH_W - 24);
  end else begin : g_atan_dn
    assign atan_k = PH_W'(ATAN_LUT[k] >> (24 - PH_W));
  end

  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    if (!y[XW-1]) begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + atan_k;
    end else begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - atan_k;
    end
  end

endmodule

// File: rtl/iq_phase_demodulator.sv
// Iterative CORDIC (vectoring) turning each I/Q sample into phase and unscaled magnitude.
// Define IQ_PHASE_UNWRAP_EN to add the 32-bit unwrapped phase accumulator.
//
// state  | meaning
// IDLE   | waiting for tick_i; captures the sample on it
// PREROT | folds left-half-plane vectors by pi
// ROTATE | ITER micro-rotations, k = 0..ITER-1
// FINISH | publishes phase/magnitude, pulses done_o on the next cycle
module iq_phase_demodulator
  import nice_cordic_pkg::*;
#(
  parameter int ITER = 22,
  parameter int IN_W = 24,
  parameter int PH_W = 24
) (
  input  logic clk_i,
  input  logic reset_i,
  iq_phase_demodulator_if.slave bus
);

  localparam int XW = IN_W + 2;
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_PREROT = PREROT;
  localparam logic [1:0] ST_ROTATE = ROTATE;
  localparam logic [1:0] ST_FINISH = FINISH;
  localparam logic [4:0] K_LAST    = 5'(ITER - 1);
  localparam logic [PH_W-1:0] PH_PI = {1'b1, {(PH_W-1){1'b0}}};

  logic [1:0]            state;
  logic signed [XW-1:0]  x, y, x_nx, y_nx;
  logic [PH_W-1:0]       z, z_nx, z_out;
  logic [4:0]            k;
  logic                  zero_q;
  logic [PH_W-1:0]       phase_q;
  logic [IN_W:0]         mag_q;
  logic                  done_q;
  logic                  overrun_q;

  cordic_microrotation #(.XW(XW), .PH_W(PH_W)) u_rot (
    .x    (x),
    .y    (y),
    .z    (z),
    .k    (k),
    .x_nx (x_nx),
    .y_nx (y_nx),
    .z_nx (z_nx)
  );

  // A zero vector has no defined angle; report 0 rather than the summed table.
  assign z_out = zero_q ? '0 : z;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      k         <= '0;
      zero_q    <= 1'b0;
      phase_q   <= '0;
      mag_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.tick_i && (state != ST_IDLE)) overrun_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.tick_i) begin
            x      <= {{2{bus.i_i[IN_W-1]}}, bus.i_i};
            y      <= {{2{bus.q_i[IN_W-1]}}, bus.q_i};
            zero_q <= (bus.i_i == '0) && (bus.q_i == '0);
            state  <= ST_PREROT;
          end
        end
        ST_PREROT: begin
          if (x[XW-1]) begin
            x <= -x;
            y <= -y;
            z <= PH_PI;
          end else begin
            z <= '0;
          end
          k     <= '0;
          state <= ST_ROTATE;
        end
        ST_ROTATE: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          k <= k + 5'd1;
          if (k == K_LAST) state <= ST_FINISH;
        end
        ST_FINISH: begin
          phase_q <= z_out;
          mag_q   <= x[IN_W:0];
          done_q  <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.phase_o     = phase_q;
  assign bus.magnitude_o = mag_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.overrun_o   = overrun_q;

`ifdef IQ_PHASE_UNWRAP_EN
  logic signed [31:0] unwrap_q;
  logic               have_prev;
  logic [PH_W-1:0]    delta;

  // Difference taken modulo one turn, so a step across +/-pi stays small.
  assign delta = z_out - phase_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      unwrap_q  <= '0;
      have_prev <= 1'b0;
    end else if (state == ST_FINISH) begin
      have_prev <= 1'b1;
      if (!have_prev) unwrap_q <= 32'(signed'(z_out));
      else            unwrap_q <= unwrap_q + 32'(signed'(delta));
    end
  end

  assign bus.phase_unwrapped_o = unwrap_q;
`endif

endmodule

// File: tb/tb_iq_phase_demodulator.sv
// Directed bench for iq_phase_demodulator: hand-computed phase/magnitude/latency/overrun/reset checks.
module tb_iq_phase_demodulator;

  localparam int ITER = 22;
  localparam int IN_W = 24;
  localparam int PH_W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iq_phase_demodulator_if #(.IN_W(IN_W), .PH_W(PH_W)) bus ();

  iq_phase_demodulator #(.ITER(ITER), .IN_W(IN_W), .PH_W(PH_W)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp_v, input longint tol);
    longint d;
    d = obs - exp_v;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp_v, tol);
    end
  endtask

  // Phase compared modulo one turn, so -pi and +pi-1 LSB count as neighbours.
  task automatic chk_ph(input string tag, input logic [PH_W-1:0] obs, input logic [PH_W-1:0] exp_v);
    logic signed [PH_W-1:0] d;
    d = obs - exp_v;
    checks++;
    assert ((d >= -2) && (d <= 2)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  // Issue one tick at a negedge; returns at the negedge where done_o is seen (or the budget runs out).
  task automatic convert(input int iv, input int qv, output int lat);
    @(negedge clk);
    bus.i_i    = IN_W'(iv);
    bus.q_i    = IN_W'(qv);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    chk_eq("busy_after_tick", 64'(bus.busy_o), 64'd1);
    lat = 0;
    while ((bus.done_o !== 1'b1) && (lat < 60)) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    bus.tick_i = 1'b0;
    bus.i_i    = '0;
    bus.q_i    = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_phase",   64'(bus.phase_o),     64'd0);
    chk_eq("rst_mag",     64'(bus.magnitude_o), 64'd0);
    chk_eq("rst_done",    64'(bus.done_o),      64'd0);
    chk_eq("rst_busy",    64'(bus.busy_o),      64'd0);
    chk_eq("rst_overrun", 64'(bus.overrun_o),   64'd0);
    rst_n = 1'b1;

    convert(4000000, 0, lat);
    chk_eq("lat_pos_i", 64'(lat), 64'(ITER + 2));
    chk_ph("ph_0deg", bus.phase_o, PH_W'(0));
    chk_tol("mag_0deg", longint'(bus.magnitude_o), 6587040, 659);
    @(negedge clk);
    chk_eq("done_pulse_len", 64'(bus.done_o), 64'd0);
    chk_ph("ph_hold", bus.phase_o, PH_W'(0));
    chk_eq("busy_idle", 64'(bus.busy_o), 64'd0);

    convert(0, 4000000, lat);
    chk_eq("lat_pos_q", 64'(lat), 64'(ITER + 2));
    chk_ph("ph_90deg", bus.phase_o, PH_W'(4194304));
    chk_tol("mag_90deg", longint'(bus.magnitude_o), 6587040, 659);

    convert(-4000000, 0, lat);
    chk_ph("ph_180deg", bus.phase_o, PH_W'(-8388608));

    convert(-8388608, -8388608, lat);
    chk_ph("ph_m135deg", bus.phase_o, PH_W'(-6291456));
    chk_tol("mag_m135deg", longint'(bus.magnitude_o), 19535980, 1954);

    convert(-8388608, 0, lat);
    chk_ph("ph_min_i", bus.phase_o, PH_W'(-8388608));
    chk_tol("mag_min_i", longint'(bus.magnitude_o), 13814026, 1382);

    convert(0, 0, lat);
    chk_eq("ph_zero", 64'(bus.phase_o), 64'd0);
    chk_eq("mag_zero", 64'(bus.magnitude_o), 64'd0);

    // Overrun: second tick five cycles after the first.
    chk_eq("overrun_clear", 64'(bus.overrun_o), 64'd0);
    @(negedge clk);
    bus.i_i    = IN_W'(0);
    bus.q_i    = IN_W'(1000000);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.i_i    = IN_W'(1000000);
    bus.q_i    = IN_W'(0);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    chk_eq("overrun_set", 64'(bus.overrun_o), 64'd1);
    dones = 0;
    for (int c = 0; c < ITER + 12; c++) begin
      if (bus.done_o === 1'b1) dones++;
      @(negedge clk);
    end
    chk_eq("overrun_one_done", 64'(dones), 64'd1);
    chk_ph("overrun_kept_first", bus.phase_o, PH_W'(4194304));
    chk_eq("overrun_sticky", 64'(bus.overrun_o), 64'd1);

    // Reset in the middle of ROTATE.
    @(negedge clk);
    bus.i_i    = IN_W'(3000000);
    bus.q_i    = IN_W'(3000000);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("midrst_phase",   64'(bus.phase_o),     64'd0);
    chk_eq("midrst_mag",     64'(bus.magnitude_o), 64'd0);
    chk_eq("midrst_busy",    64'(bus.busy_o),      64'd0);
    chk_eq("midrst_overrun", 64'(bus.overrun_o),   64'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < ITER + 6; c++) begin
      if (bus.done_o === 1'b1) dones++;
      @(negedge clk);
    end
    chk_eq("midrst_no_done", 64'(dones), 64'd0);

    convert(3000000, -3000000, lat);
    chk_eq("lat_after_rst", 64'(lat), 64'(ITER + 2));
    chk_ph("ph_m45deg", bus.phase_o, PH_W'(-2097152));
    chk_tol("mag_m45deg", longint'(bus.magnitude_o), 6986612, 699);

`ifdef IQ_PHASE_UNWRAP_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("unwrap_rst", 64'(bus.phase_unwrapped_o), 64'd0);
    rst_n = 1'b1;
    begin
      int vi [10] = '{4000000, 2828427, 0, -2828427, -4000000, -2828427, 0, 2828427, 4000000, 2828427};
      int vq [10] = '{0, 2828427, 4000000, 2828427, 0, -2828427, -4000000, -2828427, 0, 2828427};
      for (int s = 0; s < 10; s++) begin
        convert(vi[s], vq[s], lat);
        if (s == 0) chk_tol("unwrap_first", longint'(bus.phase_unwrapped_o), 0, 2);
      end
    end
    chk_tol("unwrap_final", longint'(bus.phase_unwrapped_o), 18874368, 2);
    chk_ph("unwrap_phase", bus.phase_o, PH_W'(2097152));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
